// File: rtl/intersection_controller.sv
// intersection_controller: two-way traffic light sequencer with green/yellow/all-red dwell timers
// and a pedestrian walk phase inserted at the next all-red after a request.
module intersection_controller #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    RED_TO_NS = 3'd0, NS_GREEN = 3'd1, NS_YELLOW = 3'd2, RED_TO_EW = 3'd3,
    EW_GREEN = 3'd4, EW_YELLOW = 3'd5, WALK = 3'd6
  } state_t;
  localparam logic [1:0] RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10;
  state_t state, nxt;
  logic [CNT_W-1:0] timer, dwell;
  logic next_dir, req, walk_entry;
  assign req = ped_pending | ped_req;
  assign walk_entry = (nxt == WALK) && (state != WALK);
  always_comb begin
    nxt = state;
    if (timer == '0)
      case (state)
        RED_TO_NS: nxt = req ? WALK : NS_GREEN;
        NS_GREEN:  nxt = NS_YELLOW;
        NS_YELLOW: nxt = RED_TO_EW;
        RED_TO_EW: nxt = req ? WALK : EW_GREEN;
        EW_GREEN:  nxt = EW_YELLOW;
        EW_YELLOW: nxt = RED_TO_NS;
        WALK:      nxt = next_dir ? EW_GREEN : NS_GREEN;
        default:   nxt = RED_TO_NS;
      endcase
  end
  always_comb
    dwell = (nxt == NS_GREEN  || nxt == EW_GREEN)  ? CNT_W'(GREEN_CYC - 1)  :
            (nxt == NS_YELLOW || nxt == EW_YELLOW) ? CNT_W'(YELLOW_CYC - 1) :
            (nxt == WALK)                          ? CNT_W'(WALK_CYC - 1)   :
                                                     CNT_W'(ALLRED_CYC - 1);
  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= RED_TO_NS;
      timer       <= CNT_W'(ALLRED_CYC - 1);
      next_dir    <= 1'b0;
      ns_light    <= RED;
      ew_light    <= RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      phase       <= 3'd0;
    end else begin
      state       <= nxt;
      timer       <= (timer == '0) ? dwell : timer - 1'b1;
      next_dir    <= walk_entry ? (state == RED_TO_EW) : next_dir;
      ped_pending <= walk_entry ? 1'b0 : (state != WALK && ped_req) ? 1'b1 : ped_pending;
      ns_light    <= (nxt == NS_GREEN) ? GREEN : (nxt == NS_YELLOW) ? YELLOW : RED;
      ew_light    <= (nxt == EW_GREEN) ? GREEN : (nxt == EW_YELLOW) ? YELLOW : RED;
      walk        <= (nxt == WALK);
      phase       <= nxt;
    end
endmodule
